// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: FSM state encoding and slot helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package layer_sequencer_pkg;

  // Sequencer states; one FETCH/LOAD/WAIT/STORE pass per neuron, DONE once per layer.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

  // Lowest bit of result slot k in a packed vector of width-bit words.
  function automatic int slot_base(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/layer_sequencer.sv
// Runs one shared neuron over every neuron of a fully-connected layer, collecting results.
// Latency: num_neurons*(neuron_latency+3)+1 cycles from accepted layer_go to layer_done.
// Backpressure: none; layer_go is ignored (not queued) while busy or in DONE.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int input_data_size = 4,
  parameter int num_neurons     = 3,
  parameter int resolution      = 8,
  parameter int neuron_latency  = 6,
  parameter int addr_width      = (num_neurons > 1) ? $clog2(num_neurons) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  layer_go,
  input  logic [resolution*input_data_size-1:0] input_data,
  output logic [addr_width-1:0]                 rom_addr,
  input  logic [resolution*input_data_size-1:0] rom_weight,
  input  logic [resolution-1:0]                 rom_bias,
  output logic                                  neuron_go,
  output logic [resolution*input_data_size-1:0] neuron_input_data,
  output logic [resolution*input_data_size-1:0] neuron_weight,
  output logic [resolution-1:0]                 neuron_bias,
  input  logic [resolution-1:0]                 neuron_output,
  output logic [resolution*num_neurons-1:0]     layer_output,
  output logic                                  busy,
  output logic                                  layer_done
);

  localparam int VEC_W = resolution * input_data_size;
  localparam int OUT_W = resolution * num_neurons;
  // Counter must reach neuron_latency-1; +1 keeps the width at least 1 for L=1.
  localparam int CNT_W = $clog2(neuron_latency + 1);
  localparam logic [addr_width-1:0] LAST_IDX = addr_width'(num_neurons - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(neuron_latency - 1);

  seq_state_e              state_q, state_d;
  logic [addr_width-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    go_q, go_d;
  logic [VEC_W-1:0]        in_q;
  logic [VEC_W-1:0]        wt_q;
  logic [resolution-1:0]   bias_q;
  logic [OUT_W-1:0]        out_q;
  logic                    cap_in;
  logic                    cap_wb;
  logic                    cap_out;

  // Next-state logic: sequencing, neuron index, wait counter and capture strobes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    go_d    = 1'b0;
    cap_in  = 1'b0;
    cap_wb  = 1'b0;
    cap_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (layer_go) begin
          cap_in  = 1'b1;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      // ROM sees rom_addr this cycle; data arrives next cycle.
      FETCH: state_d = LOAD;
      LOAD: begin
        cap_wb  = 1'b1;
        go_d    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = STORE;
        end
      end
      STORE: begin
        cap_out = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + addr_width'(1);
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset aborts any layer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
    end
  end

  // Datapath registers: words pass through bit-exact, results land in slot idx.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q   <= '0;
      wt_q   <= '0;
      bias_q <= '0;
      out_q  <= '0;
    end else begin
      if (cap_in) begin
        in_q <= input_data;
      end
      if (cap_wb) begin
        wt_q   <= rom_weight;
        bias_q <= rom_bias;
      end
      if (cap_out) begin
        out_q[slot_base(int'(idx_q), resolution) +: resolution] <= neuron_output;
      end
    end
  end

  assign rom_addr          = idx_q;
  assign neuron_go         = go_q;
  assign neuron_input_data = in_q;
  assign neuron_weight     = wt_q;
  assign neuron_bias       = bias_q;
  assign layer_output      = out_q;
  assign busy              = (state_q != IDLE);
  assign layer_done        = (state_q == DONE);

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench: instance A (M=3, L=6) and instance B (M=1, L=1), each with a ROM and neuron model.
// Latency: n/a.
// Backpressure: n/a.
module tb_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        go_v [2];
  logic [31:0] in_v [2];
  logic [31:0] r_w  [2];
  logic [7:0]  r_b  [2];
  logic [7:0]  n_out[2];

  logic        d_go  [2];
  logic        d_busy[2];
  logic        d_done[2];
  logic [31:0] d_nin [2];
  logic [31:0] d_nw  [2];
  logic [7:0]  d_nb  [2];
  logic [1:0]  d_addr[2];
  logic [23:0] d_lo  [2];
  logic [1:0]  a_addr;
  logic [0:0]  b_addr;
  logic [23:0] a_lo;
  logic [7:0]  b_lo;

  assign d_addr[0] = a_addr;
  assign d_addr[1] = {1'b0, b_addr};
  assign d_lo[0]   = a_lo;
  assign d_lo[1]   = {16'h0, b_lo};

  layer_sequencer #(.input_data_size(4), .num_neurons(3), .resolution(8), .neuron_latency(6)) u_a (
    .clk(clk), .reset(rst_n), .layer_go(go_v[0]), .input_data(in_v[0]), .rom_addr(a_addr),
    .rom_weight(r_w[0]), .rom_bias(r_b[0]), .neuron_go(d_go[0]), .neuron_input_data(d_nin[0]),
    .neuron_weight(d_nw[0]), .neuron_bias(d_nb[0]), .neuron_output(n_out[0]),
    .layer_output(a_lo), .busy(d_busy[0]), .layer_done(d_done[0]));

  layer_sequencer #(.input_data_size(4), .num_neurons(1), .resolution(8), .neuron_latency(1)) u_b (
    .clk(clk), .reset(rst_n), .layer_go(go_v[1]), .input_data(in_v[1]), .rom_addr(b_addr),
    .rom_weight(r_w[1]), .rom_bias(r_b[1]), .neuron_go(d_go[1]), .neuron_input_data(d_nin[1]),
    .neuron_weight(d_nw[1]), .neuron_bias(d_nb[1]), .neuron_output(n_out[1]),
    .layer_output(b_lo), .busy(d_busy[1]), .layer_done(d_done[1]));

  int M_of[2] = '{3, 1};
  int L_of[2] = '{6, 1};
  logic [31:0] rom_w[2][3];
  logic [7:0]  rom_b[2][3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0[2] = '{0, 0};
  int a_goq[$];
  int a_doneq[$];
  int b_doneq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Synchronous ROM (one-cycle read latency) and a neuron returning bias+index L cycles after go.
  int last_addr[2] = '{0, 0};
  int rem[2] = '{-1, -1};
  logic [7:0] nval[2];
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      r_w[i] = rom_w[i][last_addr[i]];
      r_b[i] = rom_b[i][last_addr[i]];
      last_addr[i] = int'(d_addr[i]);
      if (d_go[i]) begin
        rem[i]  = L_of[i];
        nval[i] = d_nb[i] + 8'(d_addr[i]);
      end else if (rem[i] >= 0) begin
        rem[i]--;
      end
      n_out[i] = (rem[i] == 0) ? nval[i] : 8'hEE;
    end
  end

  // Behavioural model: position within a layer as a cycle count, outputs by schedule.
  bit          m_act[2];
  int          m_t[2];
  int          m_idx[2];
  logic [31:0] m_in[2], m_wt[2];
  logic [7:0]  m_bs[2];
  logic [23:0] m_lo[2];

  task automatic model_reset(input int i);
    m_act[i] = 0; m_t[i] = 0; m_idx[i] = 0;
    m_in[i] = '0; m_wt[i] = '0; m_bs[i] = '0; m_lo[i] = '0;
  endtask

  task automatic model_step(input int i);
    int p, t_done, k, s;
    p = L_of[i] + 3;
    t_done = M_of[i] * p + 1;
    if (m_act[i]) begin
      m_t[i]++;
      if (m_t[i] > t_done) m_act[i] = 0;
    end else if (go_v[i]) begin
      m_act[i] = 1; m_t[i] = 1; m_in[i] = in_v[i];
    end
    if (m_act[i]) begin
      k = (m_t[i] - 1) / p;
      if (k > M_of[i] - 1) k = M_of[i] - 1;
      m_idx[i] = k;
      if (m_t[i] < t_done && (m_t[i] - 1) % p == 2) begin
        m_wt[i] = rom_w[i][k]; m_bs[i] = rom_b[i][k];
      end
      if (m_t[i] > 1 && (m_t[i] - 1) % p == 0) begin
        s = (m_t[i] - 1) / p - 1;
        m_lo[i][s*8 +: 8] = rom_b[i][s] + 8'(s);
      end
    end
  endtask

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int p;
      bit e_go, e_done;
      string tag;
      p = L_of[i] + 3;
      tag = (i == 0) ? "A" : "B";
      if (!rst_n) model_reset(i);
      e_done = m_act[i] && (m_t[i] == M_of[i] * p + 1);
      e_go   = m_act[i] && (m_t[i] < M_of[i] * p + 1) && ((m_t[i] - 1) % p == 2);
      chk({tag, ".busy"},       32'(d_busy[i]), 32'(m_act[i]));
      chk({tag, ".layer_done"}, 32'(d_done[i]), 32'(e_done));
      chk({tag, ".neuron_go"},  32'(d_go[i]),   32'(e_go));
      chk({tag, ".rom_addr"},   32'(d_addr[i]), 32'(m_idx[i]));
      chk({tag, ".n_input"},    d_nin[i],       m_in[i]);
      chk({tag, ".n_weight"},   d_nw[i],        m_wt[i]);
      chk({tag, ".n_bias"},     32'(d_nb[i]),   32'(m_bs[i]));
      chk({tag, ".layer_out"},  32'(d_lo[i]),   32'(m_lo[i]));
      if (rst_n) model_step(i);
    end
    if (d_go[0])   a_goq.push_back(cyc - t0[0]);
    if (d_done[0]) a_doneq.push_back(cyc - t0[0]);
    if (d_done[1]) b_doneq.push_back(cyc - t0[1]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go_to(input int i, input int rel);
    while (cyc - t0[i] < rel) tick();
  endtask

  task automatic start(input int i, input logic [31:0] dat);
    in_v[i] = dat;
    go_v[i] = 1'b1;
    t0[i] = cyc;
    tick();
    go_v[i] = 1'b0;
  endtask

  task automatic chk_all_zero(input int i, input string nm);
    chk({nm, ".busy"},  32'(d_busy[i]), 32'd0);
    chk({nm, ".done"},  32'(d_done[i]), 32'd0);
    chk({nm, ".go"},    32'(d_go[i]),   32'd0);
    chk({nm, ".addr"},  32'(d_addr[i]), 32'd0);
    chk({nm, ".nin"},   d_nin[i],       32'd0);
    chk({nm, ".nw"},    d_nw[i],        32'd0);
    chk({nm, ".nb"},    32'(d_nb[i]),   32'd0);
    chk({nm, ".lo"},    32'(d_lo[i]),   32'd0);
  endtask

  task automatic chk_q(input string nm, input int q[$], input int e0, input int e1, input int e2, input int n);
    int e[3];
    e = '{e0, e1, e2};
    chk({nm, ".count"}, 32'(q.size()), 32'(n));
    for (int j = 0; j < n; j++) chk({nm, ".cycle"}, 32'((j < q.size()) ? q[j] : -1), 32'(e[j]));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      go_v[i] = 1'b0; in_v[i] = '0;
      for (int k = 0; k < 3; k++) begin rom_w[i][k] = '0; rom_b[i][k] = '0; end
    end
    rom_w[0][0] = 32'h01020304; rom_w[0][1] = 32'h11121314; rom_w[0][2] = 32'h21222324;
    rom_b[0][0] = 8'd10;        rom_b[0][1] = 8'd20;        rom_b[0][2] = 8'd30;
    rom_w[1][0] = 32'hCAFEF00D; rom_b[1][0] = 8'h7F;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero(0, "rst.A");
    chk_all_zero(1, "rst.B");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // Nominal three-neuron layer; input changes while busy must not leak through.
    start(0, 32'h0A0B0C0D);
    go_to(0, 5);
    in_v[0] = 32'hDEADBEEF;
    go_to(0, 10);
    chk("t1.held_input", d_nin[0], 32'h0A0B0C0D);
    go_to(0, 32);
    chk("t1.layer_output", 32'(d_lo[0]), 32'h0020150A);
    chk_q("t1.neuron_go", a_goq, 3, 12, 21, 3);
    chk_q("t1.layer_done", a_doneq, 28, 0, 0, 1);

    // layer_go held high while busy, re-pulsed mid-layer, high in DONE and then IDLE.
    a_goq.delete(); a_doneq.delete();
    in_v[0] = 32'h11223344; go_v[0] = 1'b1; t0[0] = cyc;
    go_to(0, 11); go_v[0] = 1'b0;
    go_to(0, 15); go_v[0] = 1'b1; tick(); go_v[0] = 1'b0;
    go_to(0, 28); go_v[0] = 1'b1;
    go_to(0, 30); go_v[0] = 1'b0;
    go_to(0, 62);
    chk_q("t2.layer_done", a_doneq, 28, 57, 0, 2);

    // Reset in cycle 14 of a layer clears everything at once and suppresses layer_done.
    a_doneq.delete();
    start(0, 32'h55667788);
    go_to(0, 14);
    rst_n = 1'b0;
    #1;
    chk_all_zero(0, "t3.async.A");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t3.no_done", 32'(a_doneq.size()), 32'd0);
    start(0, 32'h55667788);
    go_to(0, 32);
    chk("t3.rerun_output", 32'(d_lo[0]), 32'h0020150A);
    chk_q("t3.rerun_done", a_doneq, 28, 0, 0, 1);

    // Negative words pass bit-exact; neuron result -3 lands in slot 0.
    rom_w[0][0] = 32'hFFFFFFFF; rom_b[0][0] = 8'hFD;
    start(0, 32'h80FF7F80);
    go_to(0, 4);
    chk("t5.n_input", d_nin[0], 32'h80FF7F80);
    chk("t5.n_weight", d_nw[0], 32'hFFFFFFFF);
    chk("t5.n_bias", 32'(d_nb[0]), 32'h000000FD);
    go_to(0, 32);
    chk("t5.slot0", 32'(d_lo[0][7:0]), 32'h000000FD);
    chk("t5.layer_output", 32'(d_lo[0]), 32'h002015FD);

    // Single-neuron layer with unit latency.
    start(1, 32'h12345678);
    go_to(1, 8);
    chk_q("t4.layer_done", b_doneq, 5, 0, 0, 1);
    chk("t4.layer_output", 32'(d_lo[1]), 32'h0000007F);
    chk("t4.rom_addr", 32'(d_addr[1]), 32'd0);
    chk("t4.n_weight", d_nw[1], 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Drives one time-shared neuron instance across a whole fully-connected layer.
- On layer_go it latches the input vector. For each neuron index it fetches the weight vector and bias from a synchronous ROM, pulses neuron_go, waits the fixed neuron latency, then captures the neuron's output into a packed layer result.
- It is the feeding and collecting end of the neuron's go/data interface. It sits between the layer's weight ROM and the neuron wrapper in the network datapath.

Parameters:
- input_data_size, 4, inputs per neuron (N).
- num_neurons, 3, neurons in the layer (M), minimum 1.
- resolution, 8, bits per data, weight, bias and output word.
- neuron_latency, 6, cycles from the neuron_go cycle to a valid neuron_output (L), minimum 1.
- addr_width, max(1,$clog2(num_neurons)), ROM address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- layer_go  in  1  start pulse; sampled only in IDLE.
- input_data  in  resolution*N  signed input vector; captured on the accepted layer_go edge.
- rom_addr  out  addr_width  ROM address; equals the current neuron index.
- rom_weight  in  resolution*N  ROM weight word; valid the cycle after rom_addr is presented.
- rom_bias  in  resolution  ROM bias word; same timing as rom_weight.
- neuron_go  out  1  one-cycle start pulse to the neuron.
- neuron_input_data  out  resolution*N  latched input vector.
- neuron_weight  out  resolution*N  registered weight vector.
- neuron_bias  out  resolution  registered bias.
- neuron_output  in  resolution  neuron result.
- layer_output  out  resolution*M  packed results; neuron k occupies bits [k*resolution +: resolution].
- busy  out  1  high in every state except IDLE.
- layer_done  out  1  one-cycle pulse when layer_output is complete.

Behaviour:
- Reset (async assert, sync release) clears:
  - state to IDLE, idx to 0, wait counter to 0;
  - rom_addr, neuron_go, busy, layer_done to 0;
  - neuron_input_data, neuron_weight, neuron_bias, layer_output to 0.
- Reset asserted mid-layer aborts the layer immediately. No layer_done is produced and partial results are cleared.
- All outputs are registered or decoded directly from the state register. rom_addr always equals idx.
- IDLE:
  - layer_go=1 at an edge captures input_data into neuron_input_data, sets idx=0 and moves to FETCH.
  - layer_go=0 stays in IDLE.
- FETCH (1 cycle): rom_addr=idx is presented to the ROM. Next state is LOAD.
- LOAD (1 cycle): ROM data is valid. At the end edge:
  - register rom_weight into neuron_weight and rom_bias into neuron_bias;
  - set neuron_go=1 and clear the wait counter;
  - move to WAIT.
- WAIT (L cycles):
  - neuron_go is high in the first WAIT cycle only (cycle G).
  - The counter increments each cycle. After L cycles the state moves to STORE, which is cycle G+L.
- STORE (1 cycle): at the end edge, write neuron_output into slot idx of layer_output.
  - If idx==M-1, go to DONE.
  - Otherwise idx increments and the state goes to FETCH.
- DONE (1 cycle): layer_done=1, then return to IDLE.
- Timing:
  - Per-neuron cost is L+3 cycles.
  - With layer_go accepted at edge E0, layer_done is high in cycle M*(L+3)+1 after E0.
- layer_go while busy is ignored, not queued. layer_go in the DONE cycle is also ignored.
- layer_output holds its value from DONE until the next accepted layer_go. It is not cleared on a new start; slots are overwritten in index order.
- neuron_input_data, neuron_weight and neuron_bias are held stable from LOAD through STORE of each neuron.
- Words are passed through unmodified; there is no arithmetic. The sign of all data is preserved bit-exact.
- M=1: a single FETCH/LOAD/WAIT/STORE pass, and idx never increments.
- idx never exceeds M-1, so there is no wrap-around.

Decomposition:
- Shared neural-network package holds the state encoding localparams (IDLE, FETCH, LOAD, WAIT, STORE, DONE) and the slot-select helper (k*resolution).
- The wait counter is small enough to stay inline; no sub-module is needed.
- The bench pairs this block with neuron_wrapper and a ROM model.

Test Plan:
- M=3, L=6, ROM biases 10/20/30, neuron model outputs bias+idx, layer_go pulse -> neuron_go in cycles 3, 12, 21; layer_done in cycle 28; layer_output = {32,21,10}.
- layer_go held high during busy and pulsed again at cycle 15 -> exactly one layer_done per accepted start; second run begins only after IDLE.
- reset driven low in cycle 14 of a layer -> all outputs 0 asynchronously, no layer_done, next layer_go runs a full layer normally.
- M=1, L=1, bias 0x7F, neuron model returns bias -> layer_done in cycle 5, layer_output=0x7F, rom_addr stays 0.
- Negative data: input_data word 0x80 and weights 0xFF -> neuron_input_data/neuron_weight bit-exact, and the neuron output -3 (0xFD) appears in slot 0.
- input_data changed while busy -> neuron_input_data unchanged until the next accepted layer_go.
